// File: rtl/jtag_gpio_seq_if.sv
// -----------------------------------------------------------------------------
// jtag_gpio_seq_if
// Request/response bus between a fabric command source and the jtag_gpio_seq
// sequencer.
//   master modport : the command source (drives req_*, observes rsp_*).
//   slave modport  : the sequencer (observes req_*, drives req_ready/rsp_*).
// Signals:
//   req_valid/req_ready : command handshake, transfer when both high
//   req_op              : 00 READ, 01 WRITE, 10 SCAN_N, 11 reserved
//   req_wdata           : GPIO value for WRITE
//   req_scan_n          : scan_n value for SCAN_N
//   rsp_valid           : one-cycle response strobe, no backpressure
//   rsp_rdata           : bits shifted out of the DR, first-out in bit 0
//   rsp_err             : qualifies rsp_valid, set for the reserved op
// -----------------------------------------------------------------------------
interface jtag_gpio_seq_if #(
    parameter int NR_GPIOS = 4
) ();
    logic                req_valid;
    logic                req_ready;
    logic [1:0]          req_op;
    logic [NR_GPIOS-1:0] req_wdata;
    logic                req_scan_n;
    logic                rsp_valid;
    logic [NR_GPIOS:0]   rsp_rdata;
    logic                rsp_err;

    modport master (
        output req_valid, req_op, req_wdata, req_scan_n,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_wdata, req_scan_n,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/jtag_gpio_seq.sv
// -----------------------------------------------------------------------------
// jtag_gpio_seq
// Drives one jtag_gpios scan chain from fabric logic. Each accepted command
// (READ, WRITE, SCAN_N) is turned into IR selects, capture/shift/update DR
// strobes and a serial tdi stream; the shifted-out chain bits are returned on
// a one-cycle response strobe. All outputs are registered.
// Ports:
//   tck        : clock shared with the jtag_gpios instance
//   reset      : synchronous active-high reset
//   bus        : jtag_gpio_seq_if.slave request/response port
//   busy       : high whenever the sequencer is not idle
//   tdi        : serial data into the chain (0 outside SHIFT)
//   capture_dr, shift_dr, update_dr : DR strobes, at most one high per cycle
//   scan_n_ir, extest_ir            : instruction selects, mutually exclusive
//   gpios_tdo  : chain output, combinational from the jtag_gpios register
// Configuration macro:
//   JTAG_GPIO_SEQ_READBACK_EN : when defined, gpios_tdo is sampled in every
//   SHIFT cycle and returned on rsp_rdata; when undefined rsp_rdata is 0 and
//   gpios_tdo is ignored. Sequencing and latency are the same either way.
// -----------------------------------------------------------------------------
module jtag_gpio_seq #(
    parameter int NR_GPIOS = 4
) (
    input  logic           tck,
    input  logic           reset,
    jtag_gpio_seq_if.slave bus,
    output logic           busy,
    output logic           tdi,
    output logic           capture_dr,
    output logic           shift_dr,
    output logic           update_dr,
    output logic           scan_n_ir,
    output logic           extest_ir,
    input  logic           gpios_tdo
);
    localparam int CNT_W = $clog2(NR_GPIOS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NR_GPIOS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SCAN  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SELECT  = 3'd1,
        CAPTURE = 3'd2,
        SHIFT   = 3'd3,
        UPDATE  = 3'd4,
        RESP    = 3'd5
    } state_e;

    state_e            state_q;
    logic [1:0]        op_q;
    logic [NR_GPIOS:0] data_q;      // remaining tdi stream, bit 0 goes out next
    logic [CNT_W-1:0]  cnt_q;       // index of the current SHIFT cycle
    logic              req_ready_q;
    logic              busy_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic              tdi_q;
    logic              capture_dr_q;
    logic              shift_dr_q;
    logic              update_dr_q;
    logic              scan_n_ir_q;
    logic              extest_ir_q;
    logic [CNT_W-1:0]  shift_last_s;

    // SCAN_N shifts a single bit; READ/WRITE shift the whole DR.
    assign shift_last_s = (op_q == OP_SCAN) ? CNT_ZERO : CNT_LAST;

    // Command FSM; every output is registered alongside the state it belongs to.
    always_ff @(posedge tck) begin
        if (reset) begin
            state_q      <= IDLE;
            op_q         <= OP_READ;
            data_q       <= '0;
            cnt_q        <= CNT_ZERO;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            tdi_q        <= 1'b0;
            capture_dr_q <= 1'b0;
            shift_dr_q   <= 1'b0;
            update_dr_q  <= 1'b0;
            scan_n_ir_q  <= 1'b0;
            extest_ir_q  <= 1'b0;
        end else begin
            // Strobes and tdi are single-cycle unless re-asserted below.
            rsp_valid_q  <= 1'b0;
            tdi_q        <= 1'b0;
            capture_dr_q <= 1'b0;
            shift_dr_q   <= 1'b0;
            update_dr_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_q        <= bus.req_op;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (bus.req_op == OP_RSVD) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else begin
                            state_q     <= SELECT;
                            scan_n_ir_q <= (bus.req_op == OP_SCAN);
                            extest_ir_q <= (bus.req_op != OP_SCAN);
                            // WRITE appends the update-enable bit as the DR MSB;
                            // READ shifts zeros so the outputs are left alone.
                            if (bus.req_op == OP_WRITE) begin
                                data_q <= {1'b1, bus.req_wdata};
                            end else if (bus.req_op == OP_SCAN) begin
                                data_q <= {{NR_GPIOS{1'b0}}, bus.req_scan_n};
                            end else begin
                                data_q <= '0;
                            end
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SELECT: begin
                    if (op_q == OP_SCAN) begin
                        state_q    <= SHIFT;
                        cnt_q      <= CNT_ZERO;
                        shift_dr_q <= 1'b1;
                        tdi_q      <= data_q[0];
                        data_q     <= {1'b0, data_q[NR_GPIOS:1]};
                    end else begin
                        state_q      <= CAPTURE;
                        capture_dr_q <= 1'b1;
                    end
                end
                CAPTURE: begin
                    state_q    <= SHIFT;
                    cnt_q      <= CNT_ZERO;
                    shift_dr_q <= 1'b1;
                    tdi_q      <= data_q[0];
                    data_q     <= {1'b0, data_q[NR_GPIOS:1]};
                end
                SHIFT: begin
                    if (cnt_q == shift_last_s) begin
                        if (op_q == OP_SCAN) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b0;
                            scan_n_ir_q <= 1'b0;
                            extest_ir_q <= 1'b0;
                        end else begin
                            state_q     <= UPDATE;
                            update_dr_q <= 1'b1;
                        end
                    end else begin
                        cnt_q      <= cnt_q + CNT_ONE;
                        shift_dr_q <= 1'b1;
                        tdi_q      <= data_q[0];
                        data_q     <= {1'b0, data_q[NR_GPIOS:1]};
                    end
                end
                UPDATE: begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    scan_n_ir_q <= 1'b0;
                    extest_ir_q <= 1'b0;
                end
                RESP: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    req_ready_q <= 1'b1;
                    scan_n_ir_q <= 1'b0;
                    extest_ir_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef JTAG_GPIO_SEQ_READBACK_EN
    logic [NR_GPIOS:0] rd_q;
    logic [NR_GPIOS:0] rsp_rdata_q;

    // Sample gpios_tdo at each SHIFT edge, before the chain moves, and publish it on RESP entry.
    always_ff @(posedge tck) begin
        if (reset) begin
            rd_q        <= '0;
            rsp_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    rd_q <= '0;
                    if (bus.req_valid && (bus.req_op == OP_RSVD)) begin
                        rsp_rdata_q <= '0;
                    end else begin
                        rsp_rdata_q <= rsp_rdata_q;
                    end
                end
                SHIFT: begin
                    rd_q[cnt_q] <= gpios_tdo;
                    // SCAN_N goes straight from its only SHIFT cycle to RESP.
                    if (op_q == OP_SCAN) begin
                        rsp_rdata_q <= {{NR_GPIOS{1'b0}}, gpios_tdo};
                    end else begin
                        rsp_rdata_q <= rsp_rdata_q;
                    end
                end
                UPDATE: begin
                    rsp_rdata_q <= rd_q;
                end
                default: begin
                    rsp_rdata_q <= rsp_rdata_q;
                end
            endcase
        end
    end

    assign bus.rsp_rdata = rsp_rdata_q;
`else
    logic unused_gpios_tdo_s;
    assign unused_gpios_tdo_s = gpios_tdo;
    assign bus.rsp_rdata      = '0;
`endif

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign busy          = busy_q;
    assign tdi           = tdi_q;
    assign capture_dr    = capture_dr_q;
    assign shift_dr      = shift_dr_q;
    assign update_dr     = update_dr_q;
    assign scan_n_ir     = scan_n_ir_q;
    assign extest_ir     = extest_ir_q;
endmodule

// File: tb/tb_jtag_gpio_seq.sv
// -----------------------------------------------------------------------------
// tb_jtag_gpio_seq
// Self-checking bench for jtag_gpio_seq with NR_GPIOS=4 and a behavioural
// jtag_gpios chain attached. Table of commands with hand-computed responses,
// per-cycle control-word expectations derived from the command timing, plus
// hand-written reset sequences.
// -----------------------------------------------------------------------------
module tb_jtag_gpio_seq;
    localparam int N = 4;
    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SCAN  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;
    // {scan_n_ir, extest_ir, capture, shift, update, tdi, busy, req_ready, rsp_valid}
    localparam logic [8:0] RESET_WORD = 9'b000000010;

    typedef struct {
        logic [1:0]   op;
        logic [N-1:0] wdata;
        logic         scan;
        logic [N-1:0] gin;
        logic         hold;
        logic [N:0]   rdata;
        logic         err;
        logic [N-1:0] gout;
    } vec_t;

    logic tck = 1'b0;
    logic reset;
    logic busy, tdi, capture_dr, shift_dr, update_dr, scan_n_ir, extest_ir, gpios_tdo;
    logic [8:0] obs_s;
    int checks = 0;
    int errors = 0;

    jtag_gpio_seq_if #(.NR_GPIOS(N)) bus_if ();

    jtag_gpio_seq #(.NR_GPIOS(N)) dut (
        .tck        (tck),
        .reset      (reset),
        .bus        (bus_if),
        .busy       (busy),
        .tdi        (tdi),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .scan_n_ir  (scan_n_ir),
        .extest_ir  (extest_ir),
        .gpios_tdo  (gpios_tdo)
    );

    always #5 tck = ~tck;

    // Behavioural jtag_gpios chain: DR = {update_enable, gpio bits}, plus scan_n bit.
    logic [N:0]   dr_q       = '0;
    logic         scan_reg_q = 1'b0;
    logic [N-1:0] gpio_out   = '0;
    logic [N-1:0] gpio_in    = '0;

    always @(posedge tck) begin
        if (extest_ir && capture_dr) dr_q <= {1'b0, gpio_in};
        else if (extest_ir && shift_dr) dr_q <= {tdi, dr_q[N:1]};
        if (scan_n_ir && shift_dr) scan_reg_q <= tdi;
        if (extest_ir && update_dr && dr_q[N]) gpio_out <= dr_q[N-1:0];
    end
    assign gpios_tdo = scan_n_ir ? scan_reg_q : dr_q[0];

    assign obs_s = {scan_n_ir, extest_ir, capture_dr, shift_dr, update_dr, tdi,
                    busy, bus_if.req_ready, bus_if.rsp_valid};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int op_latency(input logic [1:0] op);
        if ((op == OP_READ) || (op == OP_WRITE)) return N + 5;
        else if (op == OP_SCAN) return 3;
        else return 1;
    endfunction

    // Expected control word in cycle c after the accept edge (cycle 0).
    function automatic logic [8:0] exp_word(input logic [1:0] op, input logic [N:0] stream, input int c);
        int   lat;
        logic rw, scn, sel, cap, shf, upd, t;
        lat = op_latency(op);
        rw  = (op == OP_READ) || (op == OP_WRITE);
        scn = (op == OP_SCAN);
        sel = (op != OP_RSVD) && (c >= 1) && (c < lat);
        cap = rw && (c == 2);
        shf = rw ? ((c >= 3) && (c <= N + 3)) : (scn && (c == 2));
        upd = rw && (c == N + 4);
        t   = 1'b0;
        if (shf) t = stream[rw ? (c - 3) : 0];
        return {scn && sel, rw && sel, cap, shf, upd, t, c <= lat, c > lat, c == lat};
    endfunction

    // Issue one command at the next edge and check every cycle through the one after RESP.
    task automatic run_cmd(input vec_t v, input string tag);
        int         lat;
        logic [N:0] stream;
        logic [N:0] exp_rd;
        lat = op_latency(v.op);
        if (v.op == OP_WRITE)     stream = {1'b1, v.wdata};
        else if (v.op == OP_SCAN) stream = {{N{1'b0}}, v.scan};
        else                      stream = '0;
`ifdef JTAG_GPIO_SEQ_READBACK_EN
        exp_rd = v.rdata;
`else
        exp_rd = '0;
`endif
        bus_if.req_valid  = 1'b1;
        bus_if.req_op     = v.op;
        bus_if.req_wdata  = v.wdata;
        bus_if.req_scan_n = v.scan;
        gpio_in           = v.gin;
        @(posedge tck);
        #1;
        if (!v.hold) bus_if.req_valid = 1'b0;
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge tck);
            chk($sformatf("%s cyc%0d ctl", tag, c), 32'(obs_s), 32'(exp_word(v.op, stream, c)));
            if (c == lat) begin
                chk($sformatf("%s rsp_err", tag), 32'(bus_if.rsp_err), 32'(v.err));
                chk($sformatf("%s rsp_rdata", tag), 32'(bus_if.rsp_rdata), 32'(exp_rd));
                chk($sformatf("%s gpio_out", tag), 32'(gpio_out), 32'(v.gout));
            end
            if (c == lat + 1) begin
                chk($sformatf("%s rdata_hold", tag), 32'(bus_if.rsp_rdata), 32'(exp_rd));
                chk($sformatf("%s err_hold", tag), 32'(bus_if.rsp_err), 32'(v.err));
            end
        end
    endtask

    vec_t vecs[10];
    vec_t rec;
    int   rsp_seen;

    initial begin
        vecs[0] = '{OP_WRITE, 4'b1010, 1'b0, 4'b0110, 1'b0, 5'b00110, 1'b0, 4'b1010};
        vecs[1] = '{OP_READ,  4'b0000, 1'b0, 4'b0011, 1'b1, 5'b00011, 1'b0, 4'b1010};
        vecs[2] = '{OP_WRITE, 4'b0101, 1'b0, 4'b1111, 1'b0, 5'b01111, 1'b0, 4'b0101};
        vecs[3] = '{OP_READ,  4'b0000, 1'b0, 4'b1001, 1'b0, 5'b01001, 1'b0, 4'b0101};
        vecs[4] = '{OP_SCAN,  4'b0000, 1'b1, 4'b0000, 1'b0, 5'b00000, 1'b0, 4'b0101};
        vecs[5] = '{OP_SCAN,  4'b0000, 1'b0, 4'b0000, 1'b0, 5'b00001, 1'b0, 4'b0101};
        vecs[6] = '{OP_RSVD,  4'b1111, 1'b1, 4'b0000, 1'b0, 5'b00000, 1'b1, 4'b0101};
        vecs[7] = '{OP_WRITE, 4'b0000, 1'b0, 4'b0000, 1'b0, 5'b00000, 1'b0, 4'b0000};
        vecs[8] = '{OP_WRITE, 4'b1111, 1'b0, 4'b1010, 1'b0, 5'b01010, 1'b0, 4'b1111};
        vecs[9] = '{OP_READ,  4'b0000, 1'b0, 4'b1111, 1'b0, 5'b01111, 1'b0, 4'b1111};

        // Reset held 3 cycles with a command offered: nothing may be accepted.
        reset             = 1'b1;
        bus_if.req_valid  = 1'b1;
        bus_if.req_op     = OP_WRITE;
        bus_if.req_wdata  = 4'b1111;
        bus_if.req_scan_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge tck);
            chk($sformatf("reset%0d ctl", i), 32'(obs_s), 32'(RESET_WORD));
            chk($sformatf("reset%0d rdata", i), 32'(bus_if.rsp_rdata), 32'd0);
            chk($sformatf("reset%0d err", i), 32'(bus_if.rsp_err), 32'd0);
        end
        bus_if.req_valid = 1'b0;
        reset            = 1'b0;
        @(negedge tck);
        chk("post_reset ctl", 32'(obs_s), 32'(RESET_WORD));
        chk("post_reset gpio", 32'(gpio_out), 32'd0);

        for (int i = 0; i < 10; i++) begin
            run_cmd(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset during cycle 5 of a WRITE: abandon the command, no response, outputs unchanged.
        bus_if.req_valid  = 1'b1;
        bus_if.req_op     = OP_WRITE;
        bus_if.req_wdata  = 4'b0011;
        bus_if.req_scan_n = 1'b0;
        @(posedge tck);
        #1;
        bus_if.req_valid = 1'b0;
        for (int c = 1; c <= 4; c++) @(negedge tck);
        @(negedge tck);
        chk("midreset cyc5 shifting", 32'(shift_dr), 32'd1);
        reset = 1'b1;
        @(negedge tck);
        chk("midreset ctl", 32'(obs_s), 32'(RESET_WORD));
        chk("midreset rdata", 32'(bus_if.rsp_rdata), 32'd0);
        chk("midreset err", 32'(bus_if.rsp_err), 32'd0);
        chk("midreset gpio", 32'(gpio_out), 32'(4'b1111));
        reset    = 1'b0;
        rsp_seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge tck);
            if (bus_if.rsp_valid) rsp_seen++;
        end
        chk("midreset no_rsp", 32'(rsp_seen), 32'd0);
        chk("midreset gpio_after", 32'(gpio_out), 32'(4'b1111));
        chk("midreset idle", 32'(obs_s), 32'(RESET_WORD));

        // Recovery: a READ after the abandoned command behaves normally.
        rec = '{OP_READ, 4'b0000, 1'b0, 4'b0101, 1'b0, 5'b00101, 1'b0, 4'b1111};
        run_cmd(rec, "recover");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
